// File: rtl/uart_rx_word_assembler.sv
// UART receive word assembler.
// Packs NBYTES received bytes (little-endian) into one word and presents it on a
// valid/ready handshake through a single output register. A partial word is
// dropped after TOUT_CYCLES cycles of silence. Sticky flags report dropped
// complete words (overrun) and discarded partial words (timeout_err).
module uart_rx_word_assembler #(
  parameter int DBIT        = 8,
  parameter int NBYTES      = 4,
  parameter int TOUT_CYCLES = 1000000,
  parameter int TOUT_W      = 20
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rx_done,
  input  logic [DBIT-1:0]        din,
  input  logic                   word_ready,
  input  logic                   clr_err,
  output logic [NBYTES*DBIT-1:0] word_out,
  output logic                   word_valid,
  output logic [3:0]             byte_cnt,
  output logic                   overrun,
  output logic                   timeout_err
);

  localparam int                WW        = NBYTES * DBIT;
  localparam logic [3:0]        LAST_LANE = 4'(NBYTES - 1);
  localparam logic [TOUT_W-1:0] TOUT_LAST = TOUT_W'(TOUT_CYCLES - 1);

  typedef enum logic {IDLE, ASSEMBLE} state_t;

  state_t            state, state_nxt;
  logic [WW-1:0]     asm_reg, asm_nxt, word_nxt;
  logic [3:0]        cnt_nxt;
  logic [TOUT_W-1:0] tcnt, tcnt_nxt;
  logic              valid_nxt, ovr_nxt, tout_nxt;
  logic              xfer, complete;

  // Next-state logic: byte capture, timeout, handshake and sticky flags.
  always_comb begin
    state_nxt = state;
    asm_nxt   = asm_reg;
    cnt_nxt   = byte_cnt;
    tcnt_nxt  = tcnt;
    word_nxt  = word_out;
    valid_nxt = word_valid;
    ovr_nxt   = overrun & ~clr_err;
    tout_nxt  = timeout_err & ~clr_err;
    xfer      = word_valid & word_ready;
    complete  = 1'b0;

    if (xfer) valid_nxt = 1'b0;

    case (state)
      IDLE: begin
        tcnt_nxt = '0;
        if (rx_done) begin
          asm_nxt            = '0;
          asm_nxt[DBIT-1:0]  = din;
          cnt_nxt            = 4'd1;
          state_nxt          = ASSEMBLE;
        end
      end
      ASSEMBLE: begin
        if (rx_done) begin
          // A byte arriving on the expiry cycle wins over the timeout.
          tcnt_nxt = '0;
          for (int i = 0; i < NBYTES; i++) begin
            if (byte_cnt == 4'(i)) asm_nxt[i*DBIT +: DBIT] = din;
          end
          if (byte_cnt == LAST_LANE) begin
            complete  = 1'b1;
            cnt_nxt   = 4'd0;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = byte_cnt + 4'd1;
          end
        end else if (tcnt == TOUT_LAST) begin
          asm_nxt   = '0;
          cnt_nxt   = 4'd0;
          tcnt_nxt  = '0;
          tout_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          tcnt_nxt = tcnt + TOUT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A completed word is loaded only if the output register is free or is
    // being emptied this very cycle; otherwise it is dropped.
    if (complete) begin
      if (!word_valid || xfer) begin
        word_nxt  = asm_nxt;
        valid_nxt = 1'b1;
      end else begin
        ovr_nxt = 1'b1;
      end
      asm_nxt = '0;
    end
  end

  // State and datapath registers; reset discards any partial or pending word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      asm_reg     <= '0;
      byte_cnt    <= 4'd0;
      tcnt        <= '0;
      word_out    <= '0;
      word_valid  <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      asm_reg     <= asm_nxt;
      byte_cnt    <= cnt_nxt;
      tcnt        <= tcnt_nxt;
      word_out    <= word_nxt;
      word_valid  <= valid_nxt;
      overrun     <= ovr_nxt;
      timeout_err <= tout_nxt;
    end
  end

endmodule

// File: tb/tb_uart_rx_word_assembler.sv
// Bench for uart_rx_word_assembler: two instances (default timeout and a
// 100-cycle timeout) share one stimulus stream. A queue-free arithmetic model
// tracks each instance and is compared every cycle; directed literal checks
// pin the expected words and flags.
module tb_uart_rx_word_assembler;

  logic       clk = 1'b0, reset = 1'b1, rx_done = 1'b0, word_ready = 1'b0, clr_err = 1'b0;
  logic [7:0] din = 8'h00;

  logic [31:0] a_word, b_word;
  logic        a_valid, b_valid, a_ovr, b_ovr, a_tou, b_tou;
  logic [3:0]  a_cnt, b_cnt;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  uart_rx_word_assembler dut_a (
    .clk(clk), .reset(reset), .rx_done(rx_done), .din(din),
    .word_ready(word_ready), .clr_err(clr_err),
    .word_out(a_word), .word_valid(a_valid), .byte_cnt(a_cnt),
    .overrun(a_ovr), .timeout_err(a_tou)
  );

  uart_rx_word_assembler #(.DBIT(8), .NBYTES(4), .TOUT_CYCLES(100), .TOUT_W(7)) dut_b (
    .clk(clk), .reset(reset), .rx_done(rx_done), .din(din),
    .word_ready(word_ready), .clr_err(clr_err),
    .word_out(b_word), .word_valid(b_valid), .byte_cnt(b_cnt),
    .overrun(b_ovr), .timeout_err(b_tou)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int              m_cnt [2];
  int              m_sil [2];
  longint unsigned m_acc [2];
  logic [31:0]     m_word[2];
  bit              m_vld [2];
  bit              m_ovr [2];
  bit              m_tou [2];

  function automatic int tlim(input int k);
    return (k == 0) ? 1000000 : 100;
  endfunction

  always @(posedge clk or posedge reset) begin
    bit          xfer, done;
    logic [31:0] w;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_cnt[k] = 0; m_sil[k] = 0; m_acc[k] = 0;
        m_word[k] = 0; m_vld[k] = 0; m_ovr[k] = 0; m_tou[k] = 0;
      end else begin
        xfer = m_vld[k] && word_ready;
        done = 0;
        w    = 0;
        if (clr_err) begin m_ovr[k] = 0; m_tou[k] = 0; end
        if (rx_done) begin
          m_acc[k] = m_acc[k] | (64'(din) << (8 * m_cnt[k]));
          m_cnt[k] = m_cnt[k] + 1;
          m_sil[k] = 0;
          if (m_cnt[k] == 4) begin
            done = 1; w = m_acc[k][31:0]; m_acc[k] = 0; m_cnt[k] = 0;
          end
        end else if (m_cnt[k] > 0) begin
          m_sil[k] = m_sil[k] + 1;
          if (m_sil[k] >= tlim(k)) begin
            m_cnt[k] = 0; m_acc[k] = 0; m_sil[k] = 0; m_tou[k] = 1;
          end
        end
        if (done) begin
          if (!m_vld[k] || xfer) begin m_word[k] = w; m_vld[k] = 1; end
          else m_ovr[k] = 1;
        end else if (xfer) begin
          m_vld[k] = 0;
        end
      end
    end
  end

  task automatic cmp(input string n, input int k, input logic [31:0] w, input logic v,
                     input logic [3:0] c, input logic o, input logic t);
    chk({n, ".word_out"},    w, m_word[k]);
    chk({n, ".word_valid"},  {31'b0, v}, {31'b0, m_vld[k]});
    chk({n, ".byte_cnt"},    {28'b0, c}, 32'(m_cnt[k]));
    chk({n, ".overrun"},     {31'b0, o}, {31'b0, m_ovr[k]});
    chk({n, ".timeout_err"}, {31'b0, t}, {31'b0, m_tou[k]});
  endtask

  // Compare both DUTs against the model every cycle, well after the edge.
  always @(posedge clk) begin
    #3;
    cmp("A", 0, a_word, a_valid, a_cnt, a_ovr, a_tou);
    cmp("B", 1, b_word, b_valid, b_cnt, b_ovr, b_tou);
  end

  // ---------------- stimulus (always entered/left on a negedge) ----------------
  task automatic send(input logic [7:0] b);
    rx_done = 1'b1; din = b;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  logic [7:0] t1 [4];

  initial begin
    t1[0] = 8'h78; t1[1] = 8'h56; t1[2] = 8'h34; t1[3] = 8'h12;
    idle(2);
    chk("reset word_out", a_word, 32'h0);
    chk("reset word_valid", {31'b0, a_valid}, 32'h0);
    chk("reset byte_cnt", {28'b0, a_cnt}, 32'h0);
    chk("reset flags", {30'b0, a_ovr, a_tou}, 32'h0);
    reset = 1'b0;

    // Test 1: four bytes spaced 160 cycles apart, consumer always ready.
    word_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(t1[i]);
      chk("t1 byte_cnt", {28'b0, a_cnt}, (i == 3) ? 32'd0 : 32'(i + 1));
      if (i < 3) idle(159);
    end
    chk("t1 word_out", a_word, 32'h12345678);
    chk("t1 valid after last byte", {31'b0, a_valid}, 32'd1);
    idle(1);
    chk("t1 valid one cycle only", {31'b0, a_valid}, 32'd0);
    idle(200);

    // Test 2: consumer stalled, eight bytes -> second word dropped.
    word_ready = 1'b0;
    pulse_clr();
    for (int i = 1; i <= 8; i++) send(8'(i));
    chk("t2 word_out held", a_word, 32'h04030201);
    chk("t2 word_valid held", {31'b0, a_valid}, 32'd1);
    chk("t2 overrun set", {31'b0, a_ovr}, 32'd1);
    pulse_clr();
    chk("t2 overrun cleared", {31'b0, a_ovr}, 32'd0);

    // Test 3: completion coinciding with a transfer replaces the word.
    word_ready = 1'b1; idle(1); word_ready = 1'b0;
    chk("t3 drained", {31'b0, a_valid}, 32'd0);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    chk("t3 first word", a_word, 32'h44332211);
    send(8'h55); send(8'h66); send(8'h77);
    word_ready = 1'b1; send(8'h88); word_ready = 1'b0;
    chk("t3 second word", a_word, 32'h88776655);
    chk("t3 valid stays", {31'b0, a_valid}, 32'd1);
    chk("t3 no overrun", {31'b0, a_ovr}, 32'd0);
    word_ready = 1'b1; idle(1); word_ready = 1'b0;

    // Test 4: timeout on instance B after two bytes and 100 idle cycles.
    send(8'hAA); send(8'hBB);
    idle(99);
    chk("t4 no timeout yet", {31'b0, b_tou}, 32'd0);
    chk("t4 byte_cnt before expiry", {28'b0, b_cnt}, 32'd2);
    idle(1);
    chk("t4 timeout_err", {31'b0, b_tou}, 32'd1);
    chk("t4 byte_cnt cleared", {28'b0, b_cnt}, 32'd0);
    word_ready = 1'b1;
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    chk("t4 word after timeout", b_word, 32'h04030201);
    chk("t4 valid after timeout", {31'b0, b_valid}, 32'd1);

    // Test 5: byte on the expiry cycle wins; reset mid-word.
    pulse_clr();
    send(8'hC1); idle(99); send(8'hC2);
    chk("t5 no timeout on expiry byte", {31'b0, b_tou}, 32'd0);
    chk("t5 byte_cnt 2", {28'b0, b_cnt}, 32'd2);
    send(8'hC3);
    chk("t5 byte_cnt 3", {28'b0, b_cnt}, 32'd3);
    reset = 1'b1;
    #1;
    chk("t5 reset word_out B", b_word, 32'h0);
    chk("t5 reset byte_cnt B", {28'b0, b_cnt}, 32'h0);
    chk("t5 reset word_out A", a_word, 32'h0);
    chk("t5 reset valid/flags", {28'b0, a_valid, b_valid, b_ovr, b_tou}, 32'h0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    send(8'h10); send(8'h20); send(8'h30); send(8'h40);
    chk("t5 fresh word B", b_word, 32'h40302010);
    chk("t5 fresh word A", a_word, 32'h40302010);

    // Test 6: back-to-back bytes.
    send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
    chk("t6 word_out", a_word, 32'hEFBEADDE);
    chk("t6 valid", {31'b0, a_valid}, 32'd1);
    chk("t6 word_out B", b_word, 32'hEFBEADDE);
    idle(1);
    chk("t6 valid drops", {31'b0, a_valid}, 32'd0);

    idle(2);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_word_assembler.md
Name: uart_rx_word_assembler

Overview:
- Sits directly downstream of the UART receiver and consumes its one-cycle `rx_done` pulse plus the `din` byte.
- Packs NBYTES consecutive bytes, little-endian, into one word for the debug/loader unit.
- Presents each word on a valid/ready handshake and holds it in a single output register.
- Provides an inter-byte timeout that discards partial words, plus sticky overrun and timeout error flags.

Parameters:
- DBIT, 8, byte width; must match the receiver's data width.
- NBYTES, 4, bytes per word; legal range 2..15.
- TOUT_CYCLES, 1000000, clk cycles of silence after a byte before a partial word is discarded.
- TOUT_W, 20, width of the timeout counter; must satisfy 2^TOUT_W > TOUT_CYCLES.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, asynchronous, active-high.
- rx_done  in  1  one-cycle strobe from the receiver; `din` is valid in that cycle.
- din  in  DBIT  received byte.
- word_ready  in  1  consumer accepts the word when high together with word_valid.
- clr_err  in  1  synchronous clear of overrun and timeout_err.
- word_out  out  NBYTES*DBIT  assembled word.
- word_valid  out  1  word_out holds an unconsumed word.
- byte_cnt  out  4  number of bytes currently held in the partial word.
- overrun  out  1  sticky: a completed word was dropped.
- timeout_err  out  1  sticky: a partial word was discarded on timeout.

Behaviour:
- Reset values: word_out=0, word_valid=0, byte_cnt=0, overrun=0, timeout_err=0; internal assembly register=0, timeout counter=0, FSM in IDLE.
- FSM states:
  - IDLE: byte_cnt==0. On rx_done, store din in byte lane 0, set byte_cnt=1, go to ASSEMBLE.
  - ASSEMBLE: on rx_done, store din in lane byte_cnt, i.e. bits [byte_cnt*DBIT +: DBIT], and increment byte_cnt.
  - When the stored byte is lane NBYTES-1, the word is complete. Load the output register per the handshake rules below, set byte_cnt=0, go to IDLE.
- Byte ordering: the first byte received lands in word_out[DBIT-1:0]. The last byte lands in the MSBs.
- Latency: word_valid rises in the cycle after the rx_done that carries the final byte. word_out is stable whenever word_valid=1.
- Handshake rules:
  - A transfer occurs on a clk edge where word_valid=1 and word_ready=1.
  - After a transfer, word_valid drops next cycle unless a new word completes in that same cycle.
  - word_ready while word_valid=0 has no effect.
  - Assembly of the next word proceeds independently of the handshake.
- Completion while the output register is occupied:
  - If word_valid=1 and no transfer occurs that cycle, the new word is dropped. overrun is set and the output register is unchanged.
  - If word_valid=1 and a transfer occurs that same cycle, the new word is loaded and word_valid stays 1. overrun is not set.
- Timeout:
  - In ASSEMBLE, the counter increments every cycle without rx_done and clears to 0 on each rx_done.
  - When the counter reaches TOUT_CYCLES-1 with no rx_done, the following happen next cycle: partial word discarded, byte_cnt=0, counter=0, timeout_err set, state IDLE.
  - In IDLE the counter is held at 0.
  - If rx_done coincides with the expiry cycle, the byte wins. It is stored, the counter clears, and there is no timeout.
- Sticky flags:
  - overrun and timeout_err stay set until clr_err.
  - If clr_err coincides with a new set event, the set wins.
- Reset asserted mid-word or mid-handshake: all state returns to reset values immediately, and any partial word or pending output is lost.
- No arithmetic overflow is possible: byte_cnt never exceeds NBYTES-1 while stored, and the counter never exceeds TOUT_CYCLES-1.

Test Plan:
- Reset, then bytes 0x78,0x56,0x34,0x12 as rx_done pulses spaced 160 cycles apart, word_ready=1 -> word_out=0x12345678 with word_valid high exactly one cycle, asserted the cycle after the 4th rx_done; byte_cnt sequence 1,2,3,0.
- word_ready=0, send 8 bytes 0x01..0x08 -> word_out stays 0x04030201, word_valid stays 1, overrun=1 after the 8th byte. Then clr_err -> overrun=0.
- word_ready=0 for word 0x44332211, then bytes 0x55..0x88 with word_ready pulsed high in the same cycle as the 4th byte's completion -> word_out=0x88776655, word_valid stays 1, overrun=0.
- TOUT_CYCLES=100: send 2 bytes 0xAA,0xBB, then 100 idle cycles -> timeout_err=1, byte_cnt=0. Then send 0x01..0x04 -> word_out=0x04030201.
- TOUT_CYCLES=100: send a byte with rx_done exactly on the expiry cycle -> no timeout_err, byte_cnt increments. Separately, assert reset after 3 bytes -> all outputs 0; a following 4 bytes form a fresh word.
- Back-to-back rx_done on consecutive cycles (bytes 0xDE,0xAD,0xBE,0xEF) -> word_out=0xEFBEADDE, valid one cycle after the last byte.
